input_responder: RTL and testbench
==================================

// Module: input_responder
// PURPOSE
//  Responder side of the core's input handshake. The hazard unit holds input_req high while an input
//  instruction stalls in EX/MA. This block buffers bytes from the UART receiver in a FIFO, assembles
//  the requested byte or word, and returns it with a one-cycle input_valid pulse. That pulse releases the stall.
//  Sits between the UART RX and the core's I/O port.
// PARAMETERS
//  FIFO_DEPTH  16  receive FIFO entries (bytes); power of two, >= 4
// PORTS
//  clk          in   1                    clock
//  rst          in   1                    synchronous reset, active-high
//  input_req    in   1                    request level; held high until input_valid is seen
//  input_word   in   1                    1: 4-byte word, little-endian; 0: 1 byte, zero-extended
//  input_valid  out  1                    one-cycle response strobe
//  input_data   out  32                   response data; meaningful only while input_valid=1
//  rx_data      in   8                    byte from UART receiver
//  rx_valid     in   1                    one-cycle push strobe for rx_data
//  fifo_count   out  $clog2(FIFO_DEPTH)+1 bytes currently buffered
//  overflow     out  1                    sticky: a received byte was dropped
// BEHAVIOUR
//  Reset:
//   - One clock, synchronous active-high rst.
//   - Values after reset: input_valid=0, input_data=0, fifo_count=0, overflow=0, FSM=IDLE.
//   - FIFO pointers are cleared. Any partially assembled word is discarded, including on reset mid-transaction.
//  FIFO:
//   - Push on rx_valid. Pop only from COLLECT.
//   - Push and pop in the same cycle: both happen and fifo_count is unchanged.
//   - Push when full with no pop in that cycle: the byte is dropped and overflow is set. overflow clears only on rst.
//   - Push when full with a pop in the same cycle: the push is accepted and overflow is not set.
//   - Pointers wrap modulo FIFO_DEPTH. fifo_count is an up/down counter, not a pointer difference.
//  FSM (IDLE, COLLECT, RESP):
//   - IDLE:
//     - input_req=1 -> COLLECT.
//     - On that transition, latch need = input_word ? 4 : 1, clear the byte index and clear the assembly register.
//   - COLLECT:
//     - Each cycle with FIFO non-empty: pop one byte into byte lane idx (idx 0 -> bits 7:0), then idx++.
//     - When the popped byte is the last one needed -> RESP.
//     - FIFO empty: wait with no timeout.
//   - RESP:
//     - Drive input_valid=1 for exactly this cycle, with input_data = assembled word.
//     - Unused upper bytes are 0 in byte mode.
//     - Go to IDLE unconditionally; input_req is not sampled in this cycle.
//  Latency and request rules:
//   - Minimum latency: req in cycle N -> input_valid in cycle N+2 (byte mode) or N+5 (word mode), with the FIFO already stocked.
//   - The requester drops input_req combinationally in the valid cycle.
//   - A new req in the cycle after RESP is accepted normally (back-to-back inputs).
//   - input_word is sampled only on acceptance. Later changes are ignored until the next transaction.
//   - input_req falling before input_valid is a protocol violation. The transaction still completes and pulses input_valid; the data is lost.
//  Outputs: input_valid and input_data are registered (no combinational path from req to valid).
//   - input_data holds its value after the pulse until the next RESP.
// TESTING
//  1. Push 0x41; input_req=1, input_word=0 at cycle N -> input_valid=1 only at N+2, input_data=0x00000041, fifo_count 1->0.
//  2. Push 0x78,0x56,0x34,0x12; word request -> single valid pulse, input_data=0x12345678.
//  3. Word request with empty FIFO; push 1 byte every 3 cycles -> no valid until the 4th byte is popped, then one pulse.
//  4. Push 17 bytes with no pops (DEPTH=16) -> fifo_count=16, overflow=1, 17th byte absent. Push on a full FIFO in a pop cycle -> accepted, overflow unchanged.
//  5. Two byte requests back-to-back, req re-raised the cycle after valid -> two pulses 3 cycles apart, correct FIFO order.
//  6. Assert rst after 2 of 4 bytes are popped -> state IDLE, fifo_count=0, no input_valid pulse, overflow=0.

Source files
------------

// File: rtl/input_responder.sv
// Responder for the core's input handshake: buffers UART RX bytes in a FIFO and
// returns a requested byte or little-endian word with a one-cycle input_valid strobe.
module input_responder #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          input_req,
   input  logic                          input_word,
   output logic                          input_valid,
   output logic [31:0]                   input_data,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, RESP} state_t;

   state_t          state, state_nxt;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [1:0]      idx;
   logic [2:0]      need;
   logic [31:0]     asm_q, asm_next;
   logic            full, empty, push, pop, last;

   assign full  = (count == CW'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign pop   = (state == COLLECT) && !empty;
   // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
   assign push  = rx_valid && (!full || pop);
   assign last  = pop && (({1'b0, idx} + 3'd1) == need);

   assign fifo_count = count;

   always_comb begin
      asm_next = asm_q;
      if (pop) asm_next[{idx, 3'b000} +: 8] = mem[rd_ptr];
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (input_req) state_nxt = COLLECT;
         COLLECT: if (last)      state_nxt = RESP;
         RESP:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         overflow    <= 1'b0;
         idx         <= '0;
         need        <= 3'd1;
         asm_q       <= '0;
         input_valid <= 1'b0;
         input_data  <= '0;
      end else begin
         state <= state_nxt;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (rx_valid && full && !pop) overflow <= 1'b1;

         if (state == IDLE && input_req) begin
            need  <= input_word ? 3'd4 : 3'd1;
            idx   <= '0;
            asm_q <= '0;
         end else if (pop) begin
            asm_q <= asm_next;
            idx   <= idx + 2'd1;
         end

         // Strobe lands in the RESP cycle; data holds until the next response.
         input_valid <= last;
         if (last) input_data <= asm_next;
      end
   end

endmodule

// File: tb/tb_input_responder.sv
// Self-checking bench for input_responder: directed scenarios plus a randomized
// run compared against a queue-based transaction model.
module tb_input_responder;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        input_req = 1'b0;
   logic        input_word = 1'b0;
   logic        input_valid;
   logic [31:0] input_data;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic [4:0]  fifo_count;
   logic        overflow;

   int errors = 0;
   int checks = 0;

   input_responder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .input_req(input_req), .input_word(input_word),
      .input_valid(input_valid), .input_data(input_data),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .fifo_count(fifo_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Transaction-level model: byte queue plus the request being served.
   logic [7:0]  q[$];
   bit          m_busy, m_resp, m_valid, m_ovf;
   int          m_need, m_got;
   logic [31:0] m_word, m_data;

   task automatic model_update();
      bit was_idle, was_busy;
      logic [7:0] b;
      if (rst) begin
         q.delete();
         m_busy = 0; m_resp = 0; m_valid = 0; m_ovf = 0; m_data = '0;
      end else begin
         was_idle = !m_busy && !m_resp;
         was_busy = m_busy;
         m_valid = 0;
         m_resp  = 0;
         if (was_busy && q.size() > 0) begin
            b = q.pop_front();
            m_word[8*m_got +: 8] = b;
            m_got++;
            if (m_got == m_need) begin
               m_busy = 0; m_resp = 1; m_valid = 1; m_data = m_word;
            end
         end
         if (rx_valid) begin
            if (q.size() < DEPTH) q.push_back(rx_data);
            else m_ovf = 1;
         end
         if (was_idle && input_req) begin
            m_busy = 1; m_need = input_word ? 4 : 1; m_got = 0; m_word = '0;
         end
      end
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1; rx_valid = 0; input_req = 0; input_word = 0;
      step();
      rst = 0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data = b; rx_valid = 1;
      step();
      rx_valid = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (input_valid !== 1'b0 || input_data !== 32'h0 || fifo_count !== 5'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b data=%h count=%0d ovf=%b, want 0/0/0/0",
                  input_valid, input_data, fifo_count, overflow);
      end
   endtask

   task automatic test_byte();
      do_reset();
      push_byte(8'h41);
      checks++;
      if (fifo_count !== 5'd1) begin errors++; $display("FAIL byte_count_pre: got %0d want 1", fifo_count); end
      input_req = 1; input_word = 0;
      step();
      checks++;
      if (input_valid !== 1'b0) begin errors++; $display("FAIL byte_early_valid: got %b want 0", input_valid); end
      step();
      checks++;
      if (input_valid !== 1'b1 || input_data !== 32'h00000041) begin
         errors++; $display("FAIL byte_resp: valid=%b data=%h want 1/00000041", input_valid, input_data);
      end
      checks++;
      if (fifo_count !== 5'd0) begin errors++; $display("FAIL byte_count_post: got %0d want 0", fifo_count); end
      input_req = 0;
      step();
      checks++;
      if (input_valid !== 1'b0 || input_data !== 32'h00000041) begin
         errors++; $display("FAIL byte_hold: valid=%b data=%h want 0/00000041", input_valid, input_data);
      end
   endtask

   task automatic test_word();
      int pulses = 0, lat = 0;
      do_reset();
      push_byte(8'h78); push_byte(8'h56); push_byte(8'h34); push_byte(8'h12);
      input_req = 1; input_word = 1;
      for (int c = 1; c <= 10; c++) begin
         step();
         input_word = 0;  // must be ignored once accepted
         if (input_valid === 1'b1) begin
            pulses++;
            if (lat == 0) lat = c;
            checks++;
            if (input_data !== 32'h12345678) begin
               errors++; $display("FAIL word_data: got %h want 12345678", input_data);
            end
            input_req = 0;
         end
      end
      checks++;
      if (pulses != 1 || lat != 5) begin
         errors++; $display("FAIL word_pulse: pulses=%0d latency=%0d want 1/5", pulses, lat);
      end
   endtask

   task automatic test_slow();
      int pushed = 0, pulses = 0;
      logic [31:0] exp_w = '0;
      logic [7:0] b;
      do_reset();
      input_req = 1; input_word = 1;
      for (int c = 0; c < 24; c++) begin
         rx_valid = 0;
         if (c % 3 == 0 && pushed < 4) begin
            b = 8'($urandom);
            rx_data = b; rx_valid = 1;
            exp_w[8*pushed +: 8] = b;
            pushed++;
         end
         step();
         rx_valid = 0;
         checks++;
         if (input_valid !== m_valid) begin
            errors++; $display("FAIL slow_valid cycle %0d: got %b want %b", c, input_valid, m_valid);
         end
         if (input_valid === 1'b1) begin
            pulses++;
            input_req = 0;
            checks++;
            if (input_data !== exp_w || pushed != 4) begin
               errors++; $display("FAIL slow_data: got %h want %h (bytes pushed %0d)", input_data, exp_w, pushed);
            end
         end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL slow_pulses: got %0d want 1", pulses); end
   endtask

   task automatic test_overflow();
      logic [7:0] arr[17];
      logic [31:0] exp_w;
      bit seen;
      do_reset();
      for (int i = 0; i < 17; i++) begin
         arr[i] = 8'($urandom);
         push_byte(arr[i]);
      end
      checks++;
      if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_fill: count=%0d ovf=%b want 16/1", fifo_count, overflow);
      end
      for (int k = 0; k < 4; k++) begin
         exp_w = {arr[4*k+3], arr[4*k+2], arr[4*k+1], arr[4*k]};
         input_req = 1; input_word = 1;
         seen = 0;
         for (int c = 0; c < 12 && !seen; c++) begin
            step();
            if (input_valid === 1'b1) begin seen = 1; input_req = 0; end
         end
         input_req = 0;
         checks++;
         if (!seen || input_data !== exp_w) begin
            errors++; $display("FAIL ovf_drain%0d: seen=%b data=%h want %h", k, seen, input_data, exp_w);
         end
      end
      checks++;
      if (fifo_count !== 5'd0 || overflow !== 1'b1) begin
         errors++; $display("FAIL ovf_after_drain: count=%0d ovf=%b want 0/1", fifo_count, overflow);
      end
      // full FIFO, push coincides with a pop
      do_reset();
      for (int i = 0; i < 16; i++) push_byte(8'(i + 8'h20));
      checks++;
      if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
         errors++; $display("FAIL full_nopop: count=%0d ovf=%b want 16/0", fifo_count, overflow);
      end
      input_req = 1; input_word = 0;
      step();
      rx_data = 8'hA5; rx_valid = 1;
      step();
      rx_valid = 0; input_req = 0;
      checks++;
      if (input_valid !== 1'b1 || input_data !== 32'h20 || fifo_count !== 5'd16 || overflow !== 1'b0) begin
         errors++; $display("FAIL full_pop_push: valid=%b data=%h count=%0d ovf=%b want 1/00000020/16/0",
                            input_valid, input_data, fifo_count, overflow);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [7:0] a, b;
      logic [31:0] d[2];
      int t[2];
      int pulses = 0;
      bit raise = 0;
      do_reset();
      a = 8'($urandom); b = 8'($urandom);
      push_byte(a); push_byte(b);
      input_req = 1; input_word = 0;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (input_valid === 1'b1) begin
            if (pulses < 2) begin d[pulses] = input_data; t[pulses] = c; end
            pulses++;
            input_req = 0;
            raise = (pulses == 1);
         end else if (raise) begin
            input_req = 1; raise = 0;
         end
      end
      input_req = 0;
      checks++;
      if (pulses != 2) begin
         errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
      end else begin
         checks++;
         if (t[1] - t[0] != 3) begin errors++; $display("FAIL b2b_gap: got %0d want 3", t[1] - t[0]); end
         checks++;
         if (d[0] !== {24'h0, a} || d[1] !== {24'h0, b}) begin
            errors++; $display("FAIL b2b_order: got %h,%h want %h,%h", d[0], d[1], {24'h0, a}, {24'h0, b});
         end
      end
   endtask

   task automatic test_mid_reset();
      int pulses = 0;
      do_reset();
      for (int i = 0; i < 17; i++) push_byte(8'($urandom));
      input_req = 1; input_word = 1;
      step(); step(); step();
      checks++;
      if (fifo_count !== 5'd14) begin errors++; $display("FAIL midrst_pre: count=%0d want 14", fifo_count); end
      rst = 1; input_req = 0;
      step();
      rst = 0;
      checks++;
      if (fifo_count !== 5'd0 || overflow !== 1'b0 || input_valid !== 1'b0) begin
         errors++; $display("FAIL midrst_state: count=%0d ovf=%b valid=%b want 0/0/0", fifo_count, overflow, input_valid);
      end
      for (int c = 0; c < 6; c++) begin
         step();
         if (input_valid !== 1'b0) pulses++;
      end
      checks++;
      if (pulses != 0) begin errors++; $display("FAIL midrst_pulse: got %0d pulses want 0", pulses); end
      push_byte(8'h5A);
      input_req = 1; input_word = 0;
      step(); step();
      input_req = 0;
      checks++;
      if (input_valid !== 1'b1 || input_data !== 32'h5A) begin
         errors++; $display("FAIL midrst_fresh: valid=%b data=%h want 1/0000005a", input_valid, input_data);
      end
      step();
   endtask

   task automatic test_random();
      int rate;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rate = (c < 250) ? 70 : 25;
         rx_valid = ($urandom_range(0, 99) < rate);
         rx_data  = 8'($urandom);
         if (!input_req && $urandom_range(0, 2) == 0) begin
            input_req = 1; input_word = 1'($urandom_range(0, 1));
         end else if (input_req) begin
            input_word = 1'($urandom_range(0, 1));
         end
         step();
         rx_valid = 0;
         checks++;
         if (input_valid !== m_valid || fifo_count !== 5'(q.size()) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand cycle %0d: valid=%b count=%0d ovf=%b want %b/%0d/%b",
                     c, input_valid, fifo_count, overflow, m_valid, q.size(), m_ovf);
         end
         if (m_valid) begin
            checks++;
            if (input_data !== m_data) begin
               errors++; $display("FAIL rand_data cycle %0d: got %h want %h", c, input_data, m_data);
            end
            input_req = 0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_byte();
      test_word();
      test_slow();
      test_overflow();
      test_back_to_back();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
